sdram_reader: RTL and testbench

Frame-buffer read engine between the HPS/FPGA SDRAM Avalon-MM read port and the pixel pipeline. On `sdram_clk` it issues single-word Avalon reads over a frame buffer and writes returned 256-bit words into a dual-clock FIFO. On `pixel_clk` it serves one word per request to the video output logic. A sticky flag reports that the FIFO has completed its first fill, so downstream logic may start streaming.

---
 rtl/sdram_reader.sv | 157 +++++++++++++++
 tb/tb_sdram_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_reader.sv
// Frame-buffer read engine: credit-limited single-word Avalon reads into a
// dual-clock show-ahead FIFO that feeds the pixel pipeline one word per request.
`timescale 1ns/1ps
module sdram_reader #(
    parameter int SDRAM_DATA_WIDTH = 256,
    parameter int ADDR_WIDTH       = 27,
    parameter int BASE_ADDR        = 0,
    parameter int FRAME_WORDS      = 259200,
    parameter int FIFO_DEPTH       = 256,
    parameter int FILL_LEVEL       = FIFO_DEPTH
) (
    input  logic                        sdram_clk,
    input  logic                        rst,
    input  logic                        pixel_clk,
    input  logic                        frame_ready_i,
    output logic                        first_fill_flag_o,
    output logic [ADDR_WIDTH-1:0]       sdram_address_o,
    output logic [7:0]                  sdram_burstcount_o,
    input  logic                        sdram_waitrequest_i,
    input  logic [SDRAM_DATA_WIDTH-1:0] sdram_readdata_i,
    input  logic                        sdram_readdatavalid_i,
    output logic                        sdram_read_o,
    input  logic                        pixel8_req_i,
    output logic [SDRAM_DATA_WIDTH-1:0] pixel8_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS - 1);
    localparam logic [AW+1:0] DEPTH_W      = (AW+2)'(FIFO_DEPTH);
    localparam logic [AW+1:0] DEPTH_M1_W   = (AW+2)'(FIFO_DEPTH - 1);
    localparam logic [AW:0]   FILL_W       = (AW+1)'(FILL_LEVEL);

    typedef enum logic {IDLE, REQ} state_t;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [SDRAM_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // ---------------- write side (sdram_clk) ----------------
    state_t          state, state_next;
    logic [AW:0]     wr_bin, wr_gray;
    logic [AW:0]     rd_gray_meta, rd_gray_sync, rd_bin_sync;
    logic [AW:0]     wr_level, outstanding;
    logic [AW+1:0]   credit_used;
    logic            rst_d, wr_en, accept;
    logic [AW:0]     rd_gray;

    assign sdram_burstcount_o = 8'd1;
    assign rd_bin_sync = gray2bin(rd_gray_sync);
    assign wr_level    = wr_bin - rd_bin_sync;
    assign credit_used = {1'b0, wr_level} + {1'b0, outstanding};
    // Returns still in flight when reset released are dropped for one cycle.
    assign wr_en       = sdram_readdatavalid_i && !rst_d;
    // Avalon read: the command (read + address) is offered while sdram_read_o is
    // high and is taken on a cycle with waitrequest low; it is held unchanged until then.
    assign accept      = (state == REQ) && !sdram_waitrequest_i;

    always_ff @(posedge sdram_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        sdram_read_o = 1'b0;
        case (state)
            IDLE: begin
                if (frame_ready_i && (credit_used < DEPTH_W)) state_next = REQ;
            end
            REQ: begin
                sdram_read_o = 1'b1;
                if (accept && !(frame_ready_i && (credit_used < DEPTH_M1_W)))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            rst_d             <= 1'b1;
            wr_bin            <= '0;
            wr_gray           <= '0;
            rd_gray_meta      <= '0;
            rd_gray_sync      <= '0;
            outstanding       <= '0;
            sdram_address_o   <= FIRST_ADDR;
            first_fill_flag_o <= 1'b0;
        end else begin
            rst_d        <= 1'b0;
            rd_gray_meta <= rd_gray;
            rd_gray_sync <= rd_gray_meta;
            if (wr_en) begin
                wr_bin  <= wr_bin + 1'b1;
                wr_gray <= bin2gray(wr_bin + 1'b1);
            end
            case ({accept, wr_en})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (accept) begin
                if (sdram_address_o == LAST_ADDR) sdram_address_o <= FIRST_ADDR;
                else                              sdram_address_o <= sdram_address_o + 1'b1;
            end
            if (wr_level >= FILL_W) first_fill_flag_o <= 1'b1;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (wr_en) mem[wr_bin[AW-1:0]] <= sdram_readdata_i;
    end

    // ---------------- read side (pixel_clk) ----------------
    logic        rst_p_meta, rst_p;
    logic [AW:0] wr_gray_meta, wr_gray_sync, wr_bin_sync;
    logic [AW:0] rd_bin, rd_bin_next;
    logic        empty, pop;

    assign wr_bin_sync = gray2bin(wr_gray_sync);
    assign empty       = (rd_bin == wr_bin_sync);
    assign pop         = pixel8_req_i && !empty;
    assign rd_bin_next = rd_bin + {{AW{1'b0}}, pop};

    always_ff @(posedge pixel_clk) begin
        rst_p_meta <= rst;
        rst_p      <= rst_p_meta;
    end

    // pixel8_o reloads from the next head whenever that word is known written.
    always_ff @(posedge pixel_clk) begin
        if (rst_p) begin
            wr_gray_meta <= '0;
            wr_gray_sync <= '0;
            rd_bin       <= '0;
            rd_gray      <= '0;
            pixel8_o     <= '0;
        end else begin
            wr_gray_meta <= wr_gray;
            wr_gray_sync <= wr_gray_meta;
            rd_bin       <= rd_bin_next;
            rd_gray      <= bin2gray(rd_bin_next);
            if (rd_bin_next != wr_bin_sync) pixel8_o <= mem[rd_bin_next[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_sdram_reader.sv
// Bench for sdram_reader: Avalon memory model returning an incrementing count,
// a FIFO contents model, and per-cycle checks on both clock domains.
`timescale 1ns/1ps
module tb_sdram_reader;

    localparam int W       = 256;
    localparam int AWD     = 27;
    localparam int BASE    = 100;
    localparam int FRAME   = 16;
    localparam int DEPTH   = 256;
    localparam int MARGIN  = 16;

    // clock / reset
    logic sdram_clk = 1'b0;
    logic pixel_clk = 1'b0;
    always #5   sdram_clk = ~sdram_clk;
    always #6.5 pixel_clk = ~pixel_clk;

    logic           rst;
    logic           frame_ready_i;
    logic           first_fill_flag_o;
    logic [AWD-1:0] sdram_address_o;
    logic [7:0]     sdram_burstcount_o;
    logic           sdram_waitrequest_i;
    logic [W-1:0]   sdram_readdata_i;
    logic           sdram_readdatavalid_i;
    logic           sdram_read_o;
    logic           pixel8_req_i;
    logic [W-1:0]   pixel8_o;

    sdram_reader #(
        .SDRAM_DATA_WIDTH(W), .ADDR_WIDTH(AWD), .BASE_ADDR(BASE),
        .FRAME_WORDS(FRAME), .FIFO_DEPTH(DEPTH), .FILL_LEVEL(DEPTH)
    ) dut (
        .sdram_clk(sdram_clk), .rst(rst), .pixel_clk(pixel_clk),
        .frame_ready_i(frame_ready_i), .first_fill_flag_o(first_fill_flag_o),
        .sdram_address_o(sdram_address_o), .sdram_burstcount_o(sdram_burstcount_o),
        .sdram_waitrequest_i(sdram_waitrequest_i), .sdram_readdata_i(sdram_readdata_i),
        .sdram_readdatavalid_i(sdram_readdatavalid_i), .sdram_read_o(sdram_read_o),
        .pixel8_req_i(pixel8_req_i), .pixel8_o(pixel8_o)
    );

    // scoreboard state
    logic [W-1:0]   exp_q[$];
    int             pend[$];
    logic [AWD-1:0] acc_hist[32];
    int tests = 0, fails = 0;
    int wr_cnt = 0, accepts = 0, pops = 0, ret_cnt = 0, cyc = 0, mem_lat = 1;
    bit full_seen = 0, full_seen_d = 0, chk_en = 0, stress_en = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sclk(input int n);
        repeat (n) begin @(posedge sdram_clk); #2; end
    endtask

    // Avalon slave model: data = index of the return since reset, in issue order.
    initial begin : mem_model
        logic acc, stall_prev;
        logic [AWD-1:0] addr_now, addr_prev;
        int stall_left, idle_left;
        stall_prev = 0; stall_left = 0; idle_left = 0; addr_prev = '0;
        sdram_waitrequest_i   = 1'b0;
        sdram_readdatavalid_i = 1'b0;
        sdram_readdata_i      = '0;
        forever begin
            @(negedge sdram_clk);
            if (!rst && chk_en) begin
                check("burstcount", sdram_burstcount_o, 1);
                if (stall_prev) begin
                    check("stall_read", sdram_read_o, 1);
                    check("stall_addr", sdram_address_o, addr_prev);
                end
                if (sdram_read_o) check("credit_bound", (accepts - pops) <= DEPTH - 1, 1);
                if (full_seen_d) check("fill_flag_set", first_fill_flag_o, 1);
                if (pops == 0 && wr_cnt < DEPTH) check("fill_flag_early", first_fill_flag_o, 0);
            end
            acc        = sdram_read_o && !sdram_waitrequest_i && !rst;
            stall_prev = sdram_read_o && sdram_waitrequest_i && !rst;
            addr_prev  = sdram_address_o;
            addr_now   = sdram_address_o;
            @(posedge sdram_clk); #1;
            cyc++;
            if (rst) begin
                exp_q.delete(); pend.delete();
                wr_cnt = 0; accepts = 0; ret_cnt = 0;
                full_seen = 0; full_seen_d = 0; stall_prev = 0;
                acc_hist[0] = '1;
                sdram_readdatavalid_i = 1'b0;
                sdram_waitrequest_i   = 1'b0;
            end else begin
                if (sdram_readdatavalid_i) begin
                    exp_q.push_back(sdram_readdata_i);
                    wr_cnt++;
                end
                full_seen_d = full_seen;
                if (wr_cnt - pops >= DEPTH) full_seen = 1;
                if (acc) begin
                    check("accept_addr", addr_now, AWD'(BASE + (accepts % FRAME)));
                    if (accepts < 32) acc_hist[accepts] = addr_now;
                    accepts++;
                    pend.push_back(cyc + mem_lat);
                end
                if (pend.size() > 0 && pend[0] <= cyc + 1) begin
                    void'(pend.pop_front());
                    sdram_readdatavalid_i = 1'b1;
                    sdram_readdata_i      = W'(ret_cnt);
                    ret_cnt++;
                end else begin
                    sdram_readdatavalid_i = 1'b0;
                end
                if (!stress_en) begin
                    sdram_waitrequest_i = 1'b0;
                end else if (stall_left > 0) begin
                    sdram_waitrequest_i = 1'b1; stall_left--;
                end else if (idle_left > 0) begin
                    sdram_waitrequest_i = 1'b0; idle_left--;
                end else begin
                    sdram_waitrequest_i = 1'b0;
                    stall_left = $urandom_range(3, 1);
                    idle_left  = $urandom_range(7, 0);
                end
            end
        end
    end

    // Compare: whenever the head word is certainly visible, it must be word[pops].
    always @(negedge pixel_clk) begin
        if (chk_en && !rst && (wr_cnt - pops >= MARGIN))
            check("stream_word", pixel8_o, exp_q[pops]);
    end

    // Pop driver: only requests while the model knows the FIFO holds data.
    task automatic do_pops(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int gap, guard;
            gap = $urandom_range(maxgap, 0);
            guard = 0;
            @(negedge pixel_clk);
            for (int g = 0; g < gap; g++) begin pixel8_req_i = 1'b0; @(negedge pixel_clk); end
            while ((wr_cnt - pops < MARGIN) && guard < 5000) begin
                pixel8_req_i = 1'b0; guard++; @(negedge pixel_clk);
            end
            if (guard >= 5000) begin
                tests++; fails++;
                $display("FAIL pop_wait: data never available after %0d pops", pops);
                break;
            end
            pixel8_req_i = 1'b1;
            @(posedge pixel_clk);
            pops++;
        end
        @(negedge pixel_clk);
        pixel8_req_i = 1'b0;
    endtask

    task automatic empty_reqs();
        repeat (3) begin
            @(negedge pixel_clk); pixel8_req_i = 1'b1;
            @(negedge pixel_clk); pixel8_req_i = 1'b0;
        end
        repeat (2) @(negedge pixel_clk);
        check("empty_req_hold", pixel8_o, 0);
    endtask

    initial begin : main
        int g, acc0;
        rst = 1'b1; frame_ready_i = 1'b0; pixel8_req_i = 1'b0;
        sclk(6);
        rst = 1'b0;
        sclk(1);
        chk_en = 1;
        repeat (6) @(negedge pixel_clk);
        check("rst_read", sdram_read_o, 0);
        check("rst_addr", sdram_address_o, BASE);
        check("rst_burst", sdram_burstcount_o, 1);
        check("rst_flag", first_fill_flag_o, 0);
        check("rst_pixel", pixel8_o, 0);
        empty_reqs();

        // reset then fill
        frame_ready_i = 1'b1;
        g = 0;
        while (!first_fill_flag_o && g < 3000) begin sclk(1); g++; end
        check("fill_flag", first_fill_flag_o, 1);
        check("fill_head", pixel8_o, 0);
        check("addr_first", acc_hist[0], 100);
        check("addr_last", acc_hist[15], 115);
        check("addr_wrap", acc_hist[16], 100);
        sclk(256);
        check("fill_accepts", accepts, 256);
        check("fill_writes", wr_cnt, 256);

        // streaming under waitrequest stress
        stress_en = 1;
        do_pops(1024, 9);
        sclk(10);
        check("stream_end", pixel8_o, 1024);

        // backpressure
        sclk(2000);
        check("bp_full", accepts - pops, 256);
        check("bp_idle", sdram_read_o, 0);
        do_pops(300, 3);
        sclk(50);
        check("bp_resume", accepts - pops, 256);

        // frame_ready low: no new reads even with credit
        stress_en = 0;
        frame_ready_i = 1'b0;
        sclk(5);
        acc0 = accepts;
        do_pops(50, 2);
        sclk(50);
        check("not_ready_no_issue", accepts, acc0);

        // mid-run reset with several reads outstanding
        mem_lat = 8;
        frame_ready_i = 1'b1;
        g = 0;
        while (!(pend.size() >= 5 && sdram_read_o) && g < 200) begin sclk(1); g++; end
        check("mid_rst_setup", pend.size() >= 5 && sdram_read_o, 1);
        rst = 1'b1;
        sclk(1);
        pops = 0;
        check("mid_rst_read", sdram_read_o, 0);
        check("mid_rst_flag", first_fill_flag_o, 0);
        sclk(7);
        mem_lat = 1;
        rst = 1'b0;
        repeat (4) @(negedge pixel_clk);
        check("mid_rst_pixel", pixel8_o, 0);
        g = 0;
        while (accepts < 1 && g < 100) begin sclk(1); g++; end
        check("mid_rst_restart_addr", acc_hist[0], 100);
        g = 0;
        while (!first_fill_flag_o && g < 3000) begin sclk(1); g++; end
        check("refill_flag", first_fill_flag_o, 1);
        do_pops(200, 5);
        sclk(20);
        check("restream_end", pixel8_o, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
